// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and constants for the UART transmit scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } seq_state_t;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;
    localparam int   NUM_REQ = 2;

    // Number of bytes still to send after the first one of a request.
    function automatic logic [1:0] bytes_after_first(input logic size);
        return (size == SZ_WORD) ? 2'd3 : 2'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_req_slot.sv
// ============================================================================
// Module : uart_tx_req_slot
// Brief  : One-entry request holding register with valid/ready and clear-on-grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_req_slot (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_valid,
    input  logic        i_size,
    input  logic [31:0] i_data,
    input  logic        i_clr,
    output logic        o_ready,
    output logic        o_full,
    output logic        o_size,
    output logic [31:0] o_data
);

    logic        r_full;
    logic        r_size;
    logic [31:0] r_data;

    // A full slot is never ready, so accept and clear cannot collide.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_full <= 1'b0;
            r_size <= 1'b0;
            r_data <= 32'h0;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_size <= i_size;
            r_data <= i_data;
        end
    end

    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_size  = r_size;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module : uart_tx_sched
// Brief  : Two-requester byte/word scheduler in front of uart_tx.
//          Define UART_TX_SCHED_RR_EN for round-robin ties (else fixed priority).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_sched
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    input  logic        req0_size,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_size,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [7:0]  sdata,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        sched_busy,
    output logic        grant_id,
    output logic        done
);

    logic [NUM_REQ-1:0]        w_valid;
    logic [NUM_REQ-1:0]        w_size;
    logic [NUM_REQ-1:0][31:0]  w_data;
    logic [NUM_REQ-1:0]        w_ready;
    logic [NUM_REQ-1:0]        w_full;
    logic [NUM_REQ-1:0]        w_clr;
    logic [NUM_REQ-1:0]        w_slot_size;
    logic [NUM_REQ-1:0][31:0]  w_slot_data;

    logic        w_pick;
    logic        w_grant;
    logic        w_sel_size;
    logic [31:0] w_sel_data;

    seq_state_t  r_state;
    logic [31:0] r_buf;
    logic [1:0]  r_bytes_left;
    logic        r_tx_start;
    logic        r_grant_id;
    logic        r_done;

    assign w_valid   = {req1_valid, req0_valid};
    assign w_size    = {req1_size,  req0_size};
    assign w_data[0] = req0_data;
    assign w_data[1] = req1_data;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            uart_tx_req_slot u_slot (
                .clk     (clk),
                .rstn    (rstn),
                .i_valid (w_valid[gi]),
                .i_size  (w_size[gi]),
                .i_data  (w_data[gi]),
                .i_clr   (w_clr[gi]),
                .o_ready (w_ready[gi]),
                .o_full  (w_full[gi]),
                .o_size  (w_slot_size[gi]),
                .o_data  (w_slot_data[gi])
            );
        end
    endgenerate

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];

`ifdef UART_TX_SCHED_RR_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_pick;
        end
    end

    always_comb begin
        w_pick = ~w_full[0];
        if (&w_full) begin
            w_pick = ~r_last;
        end
    end
`else
    always_comb begin
        w_pick = ~w_full[0];
    end
`endif

    // Arbitration only from idle, and never while uart_tx is still busy.
    assign w_grant    = (r_state == S_IDLE) && (|w_full) && !tx_busy;
    assign w_clr      = w_grant ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
    assign w_sel_size = w_slot_size[w_pick];
    assign w_sel_data = w_slot_data[w_pick];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_buf        <= 32'h0;
            r_bytes_left <= 2'd0;
            r_tx_start   <= 1'b0;
            r_grant_id   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_buf        <= w_sel_data;
                        r_bytes_left <= bytes_after_first(w_sel_size);
                        r_grant_id   <= w_pick;
                        r_tx_start   <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_bytes_left != 2'd0) begin
                            r_buf        <= {8'h00, r_buf[31:8]};
                            r_bytes_left <= r_bytes_left - 2'd1;
                            r_tx_start   <= 1'b1;
                            r_state      <= S_START;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The low byte of the shift buffer is the byte currently offered to uart_tx.
    assign sdata      = r_buf[7:0];
    assign tx_start   = r_tx_start;
    assign grant_id   = r_grant_id;
    assign done       = r_done;
    assign sched_busy = (r_state != S_IDLE) || (|w_full);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module : tb_uart_tx_sched
// Brief  : Scoreboard bench for uart_tx_sched with a behavioural uart_tx model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_sched;

    typedef struct {
        int          acc_edge;
        logic        size;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0_valid = 1'b0, req0_size = 1'b0;
    logic [31:0] req0_data = 32'h0;
    logic        req1_valid = 1'b0, req1_size = 1'b0;
    logic [31:0] req1_data = 32'h0;
    logic        req0_ready, req1_ready;
    logic [7:0]  sdata;
    logic        tx_start, tx_busy, sched_busy, grant_id, done;

    always #5 clk = ~clk;

    uart_tx_sched dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_size  (req0_size),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_size  (req1_size),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sdata      (sdata),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .sched_busy (sched_busy),
        .grant_id   (grant_id),
        .done       (done)
    );

    // uart_tx stand-in: busy for a random number of cycles after each start.
    logic mb = 1'b0;
    int   bcnt = 0;
    logic force_busy = 1'b0;
    int   cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            mb   <= 1'b0;
            bcnt <= 0;
        end else if (mb) begin
            if (bcnt == 0) mb <= 1'b0;
            else           bcnt <= bcnt - 1;
        end else if (tx_start) begin
            mb   <= 1'b1;
            bcnt <= int'($urandom_range(1, 6));
        end
    end
    assign tx_busy = mb | force_busy;

    req_t       pq0[$];
    req_t       pq1[$];
    logic [7:0] expb[$];
    bit         cur_active = 1'b0;
    bit         cur_grant  = 1'b0;
    bit         last_g     = 1'b1;
    int         n_cmp = 0, n_bad = 0;
    int         n_acc = 0, n_done = 0, n_starts = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor: a start with no request in progress is a new grant; pick it by the arbitration rule.
    always @(negedge clk) begin
        if (rstn) begin
            if (tx_start) begin
                bit   e0, e1, pick;
                req_t r;
                n_starts++;
                chk("busy_at_start", {31'h0, tx_busy}, 32'h0);
                if (!cur_active) begin
                    e0 = (pq0.size() > 0) && (pq0[0].acc_edge < cyc);
                    e1 = (pq1.size() > 0) && (pq1[0].acc_edge < cyc);
                    if (!e0 && !e1) begin
                        fail("start_without_request");
                    end else begin
`ifdef UART_TX_SCHED_RR_EN
                        if (e0 && e1) pick = ~last_g;
                        else          pick = !e0;
`else
                        pick = !e0;
`endif
                        last_g = pick;
                        if (!pick) r = pq0.pop_front();
                        else       r = pq1.pop_front();
                        for (int k = 0; k < (r.size ? 4 : 1); k++)
                            expb.push_back(r.data[8*k +: 8]);
                        cur_active = 1'b1;
                        cur_grant  = pick;
                    end
                end
                if (cur_active) begin
                    if (expb.size() == 0) fail("start_after_last_byte");
                    else chk("sdata", {24'h0, sdata}, {24'h0, expb.pop_front()});
                    chk("grant_id", {31'h0, grant_id}, {31'h0, cur_grant});
                end
            end
            if (done) begin
                chk("done_while_active", {31'h0, cur_active}, 32'h1);
                chk("bytes_left_at_done", expb.size(), 32'h0);
                cur_active = 1'b0;
                expb.delete();
                n_done++;
            end
        end
    end

    task automatic drive(input bit r, input bit v, input bit sz, input logic [31:0] d);
        if (!r) begin req0_valid = v; req0_size = sz; req0_data = d; end
        else    begin req1_valid = v; req1_size = sz; req1_data = d; end
    endtask

    task automatic send(input bit r, input bit sz, input logic [31:0] d);
        bit   rdy;
        int   ce;
        req_t q;
        @(negedge clk);
        drive(r, 1'b1, sz, d);
        for (int t = 0; t < 4000; t++) begin
            rdy = r ? req1_ready : req0_ready;
            ce  = cyc;
            @(posedge clk);
            if (rdy) begin
                q.acc_edge = ce + 1;
                q.size     = sz;
                q.data     = d;
                if (!r) pq0.push_back(q);
                else    pq1.push_back(q);
                n_acc++;
                #1;
                drive(r, 1'b0, 1'b0, 32'h0);
                return;
            end
            @(negedge clk);
        end
        fail("accept_timeout");
        drive(r, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            #1;
            if (!sched_busy && !mb && !cur_active && pq0.size() == 0 && pq1.size() == 0)
                return;
        end
        fail("idle_timeout");
    endtask

    task automatic chk_reset_vals();
        chk("rst_req0_ready", {31'h0, req0_ready}, 32'h1);
        chk("rst_req1_ready", {31'h0, req1_ready}, 32'h1);
        chk("rst_tx_start",   {31'h0, tx_start},   32'h0);
        chk("rst_sdata",      {24'h0, sdata},      32'h0);
        chk("rst_sched_busy", {31'h0, sched_busy}, 32'h0);
        chk("rst_grant_id",   {31'h0, grant_id},   32'h0);
        chk("rst_done",       {31'h0, done},       32'h0);
    endtask

    initial begin
        int s0, d0;
        bit ok;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rstn = 1'b1;

        // Single byte: one start, ready drops for exactly one cycle.
        s0 = n_starts; d0 = n_done;
        send(1'b0, 1'b0, 32'h0000_0041);
        @(negedge clk);
        chk("ready0_low_after_accept", {31'h0, req0_ready}, 32'h0);
        @(negedge clk);
        chk("ready0_back_after_grant", {31'h0, req0_ready}, 32'h1);
        wait_idle();
        chk("byte_start_count", n_starts - s0, 32'd1);
        chk("byte_done_count",  n_done - d0,   32'd1);

        // Word: four little-endian bytes, one done.
        s0 = n_starts; d0 = n_done;
        send(1'b0, 1'b1, 32'h4443_4241);
        wait_idle();
        chk("word_start_count", n_starts - s0, 32'd4);
        chk("word_done_count",  n_done - d0,   32'd1);

        // Simultaneous word requests; a lone req0 between pairs shifts the RR pointer.
        fork
            send(1'b0, 1'b1, 32'hA0A1A2A3);
            send(1'b1, 1'b1, 32'hB0B1B2B3);
        join
        wait_idle();
        fork
            send(1'b0, 1'b1, 32'hC0C1C2C3);
            send(1'b1, 1'b1, 32'hD0D1D2D3);
        join
        wait_idle();
        send(1'b0, 1'b0, 32'h0000_0077);
        wait_idle();
        fork
            send(1'b0, 1'b1, 32'hE0E1E2E3);
            send(1'b1, 1'b1, 32'hF0F1F2F3);
        join
        wait_idle();

        // Byte queued behind an in-flight word.
        s0 = n_starts;
        send(1'b0, 1'b1, 32'h1234_5678);
        send(1'b0, 1'b0, 32'h0000_009C);
        wait_idle();
        chk("queued_start_count", n_starts - s0, 32'd5);

        // Reset after the first byte of a word has gone out.
        s0 = n_starts;
        send(1'b0, 1'b1, 32'hA1B2C3D4);
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (n_starts >= s0 + 2) begin ok = 1'b1; break; end
        end
        if (!ok) fail("second_byte_timeout");
        #1;
        rstn = 1'b0;
        pq0.delete(); pq1.delete(); expb.delete();
        cur_active = 1'b0; last_g = 1'b1;
        n_acc = 0; n_done = 0;
        @(negedge clk);
        chk_reset_vals();
        #1 rstn = 1'b1;
        s0 = n_starts;
        send(1'b0, 1'b0, 32'h0000_0055);
        wait_idle();
        chk("post_reset_start_count", n_starts - s0, 32'd1);

        // uart_tx busy at grant time holds the sequencer in idle.
        s0 = n_starts;
        @(negedge clk);
        force_busy = 1'b1;
        send(1'b1, 1'b0, 32'h0000_005A);
        repeat (6) begin
            @(negedge clk);
            chk("no_start_while_busy", {31'h0, tx_start}, 32'h0);
        end
        chk("sched_busy_while_held", {31'h0, sched_busy}, 32'h1);
        force_busy = 1'b0;
        wait_idle();
        chk("held_start_count", n_starts - s0, 32'd1);

        // Random mixed traffic from both requesters.
        fork
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                send(1'b0, 1'($urandom_range(0, 1)), $urandom);
            end
            for (int j = 0; j < 20; j++) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                send(1'b1, 1'($urandom_range(0, 1)), $urandom);
            end
        join
        wait_idle();
        chk("done_balance", n_done, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        fail("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
